mux_4_1_rr_sched: RTL and testbench



---
 rtl/mux_4_1_rr_sched.sv | 102 ++++++++++
 tb/tb_mux_4_1_rr_sched.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/mux_4_1_rr_sched.sv
// Round-robin sequencer driving the select of a shared 4:1 mux, with per-grant quantum.
// Optional MUX_RR_LOCK_EN adds a lock input that lets the current owner outlast its quantum.
module mux_4_1_rr_sched #(
    parameter int WIDTH   = 1,
    parameter int QUANTUM = 4
) (
    input  logic               CLOCK_50,
    input  logic               reset,
    input  logic [3:0]         req,
    input  logic [4*WIDTH-1:0] data_in,
`ifdef MUX_RR_LOCK_EN
    input  logic               lock,
`endif
    output logic [3:0]         grant,
    output logic [1:0]         sel,
    output logic [WIDTH-1:0]   data_out,
    output logic               valid
);

    typedef enum logic {IDLE, GRANT} state_t;

    localparam logic [7:0] CNT_MAX = 8'(QUANTUM - 1);

    state_t     state;
    logic [7:0] count;
    logic [1:0] last;
    logic       hold_lock;
    logic       release_now;
    logic [2:0] pick_idle;
    logic [2:0] pick_rel;

    // Returns {found, index}: first requester scanning last+1, last+2, last+3, last.
    function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] from);
        logic [2:0] res;
        logic [1:0] cand;
        res = 3'b000;
        for (int k = 1; k <= 4; k++) begin
            cand = from + 2'(k);
            if (!res[2] && r[cand]) res = {1'b1, cand};
        end
        return res;
    endfunction

`ifdef MUX_RR_LOCK_EN
    assign hold_lock = lock;
`else
    assign hold_lock = 1'b0;
`endif

    assign release_now = !req[sel] || ((count == CNT_MAX) && !hold_lock);
    assign pick_idle   = rr_pick(req, last);
    assign pick_rel    = rr_pick(req, sel);

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state <= IDLE;
            grant <= 4'b0000;
            sel   <= 2'd0;
            count <= 8'd0;
            last  <= 2'd3;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_idle[2]) begin
                        grant <= 4'b0001 << pick_idle[1:0];
                        sel   <= pick_idle[1:0];
                        count <= 8'd0;
                        state <= GRANT;
                    end
                end
                GRANT: begin
                    if (release_now) begin
                        // The owner becomes the new pointer and re-arbitration happens in the same edge.
                        last <= sel;
                        if (pick_rel[2]) begin
                            grant <= 4'b0001 << pick_rel[1:0];
                            sel   <= pick_rel[1:0];
                            count <= 8'd0;
                        end else begin
                            grant <= 4'b0000;
                            count <= 8'd0;
                            state <= IDLE;
                        end
                    end else if (count != CNT_MAX) begin
                        count <= count + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign valid = |grant;

    always_comb begin
        data_out = '0;
        for (int i = 0; i < 4; i++) begin
            if (valid && (sel == 2'(i))) data_out = data_in[i*WIDTH +: WIDTH];
        end
    end

endmodule

// File: tb/tb_mux_4_1_rr_sched.sv
// Directed bench for mux_4_1_rr_sched: a QUANTUM=4 instance and a QUANTUM=1 instance, WIDTH=8.
module tb_mux_4_1_rr_sched;

    logic        clk;
    logic        reset;
    logic [3:0]  req;
    logic [3:0]  req1;
    logic [31:0] data_in;
    logic        lock;
    logic [3:0]  grant, grant1;
    logic [1:0]  sel, sel1;
    logic [7:0]  data_out, data_out1;
    logic        valid, valid1;

    int checks;
    int failures;

    mux_4_1_rr_sched #(.WIDTH(8), .QUANTUM(4)) dut (
        .CLOCK_50 (clk),
        .reset    (reset),
        .req      (req),
        .data_in  (data_in),
`ifdef MUX_RR_LOCK_EN
        .lock     (lock),
`endif
        .grant    (grant),
        .sel      (sel),
        .data_out (data_out),
        .valid    (valid)
    );

    mux_4_1_rr_sched #(.WIDTH(8), .QUANTUM(1)) dut_q1 (
        .CLOCK_50 (clk),
        .reset    (reset),
        .req      (req1),
        .data_in  (data_in),
`ifdef MUX_RR_LOCK_EN
        .lock     (1'b0),
`endif
        .grant    (grant1),
        .sel      (sel1),
        .data_out (data_out1),
        .valid    (valid1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [3:0] eg;
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        req      = 4'b0000;
        req1     = 4'b0000;
        lock     = 1'b0;
        // Source 0..3 data bytes: 96, 3C, A5, D3.
        data_in  = 32'hD3A5_3C96;

        // Test 1: reset with all requesting, then rotation with 4-cycle quanta.
        req = 4'b1111;
        tick();
        chk("rst_grant", {28'd0, grant}, 32'd0);
        chk("rst_sel",   {30'd0, sel},   32'd0);
        chk("rst_valid", {31'd0, valid}, 32'd0);
        chk("rst_data",  {24'd0, data_out}, 32'd0);
        reset = 1'b0;
        for (int k = 0; k < 17; k++) begin
            tick();
            eg = 4'b0001 << ((k / 4) % 4);
            chk("rot_grant", {28'd0, grant}, {28'd0, eg});
            chk("rot_sel",   {30'd0, sel},   32'((k / 4) % 4));
            chk("rot_data",  {24'd0, data_out}, {24'd0, data_in[((k / 4) % 4)*8 +: 8]});
        end

        // Test 2: single requester 2 stays granted across quantum boundaries.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        req = 4'b0100;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("solo_grant", {28'd0, grant}, 32'h4);
            chk("solo_sel",   {30'd0, sel},   32'd2);
            chk("solo_data",  {24'd0, data_out}, 32'hA5);
        end
        req = 4'b0000;
        tick();
        chk("drop_grant", {28'd0, grant}, 32'd0);
        chk("drop_valid", {31'd0, valid}, 32'd0);
        chk("drop_sel",   {30'd0, sel},   32'd2);
        chk("drop_data",  {24'd0, data_out}, 32'd0);

        // Test 3: owner 1 drops early, grant moves to 3 and its count restarts.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        req = 4'b1010;
        tick();
        chk("t3_first", {28'd0, grant}, 32'h2);
        tick();
        chk("t3_hold", {28'd0, grant}, 32'h2);
        req = 4'b1000;
        tick();
        chk("t3_move", {28'd0, grant}, 32'h8);
        chk("t3_sel",  {30'd0, sel},   32'd3);
        req = 4'b1001;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("t3_quantum", {28'd0, grant}, 32'h8);
        end
        tick();
        chk("t3_expire", {28'd0, grant}, 32'h1);

        // Test 4: reset mid-quantum, then pointer back at 3.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        req = 4'b0100;
        tick();
        tick();
        chk("t4_pre", {28'd0, grant}, 32'h4);
        reset = 1'b1;
        req = 4'b0110;
        tick();
        chk("t4_grant", {28'd0, grant}, 32'd0);
        chk("t4_sel",   {30'd0, sel},   32'd0);
        chk("t4_data",  {24'd0, data_out}, 32'd0);
        reset = 1'b0;
        tick();
        chk("t4_regrant", {28'd0, grant}, 32'h2);
        chk("t4_data2",   {24'd0, data_out}, 32'h3C);

        // Test 5: QUANTUM=1 alternates every edge.
        req = 4'b0000;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        req1 = 4'b1001;
        for (int k = 0; k < 6; k++) begin
            tick();
            eg = (k % 2 == 0) ? 4'b0001 : 4'b1000;
            chk("q1_grant", {28'd0, grant1}, {28'd0, eg});
            chk("q1_sel",   {30'd0, sel1},   (k % 2 == 0) ? 32'd0 : 32'd3);
        end
        req1 = 4'b0000;

`ifdef MUX_RR_LOCK_EN
        // Test 6: lock keeps owner 0 past its quantum; dropping req still releases.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        req  = 4'b1111;
        lock = 1'b1;
        for (int k = 0; k < 9; k++) begin
            tick();
            chk("lock_hold", {28'd0, grant}, 32'h1);
        end
        lock = 1'b0;
        tick();
        chk("lock_drop", {28'd0, grant}, 32'h2);
        lock = 1'b1;
        req  = 4'b1101;
        tick();
        chk("lock_reqdrop", {28'd0, grant}, 32'h4);
        lock = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
